// File: rtl/scratchpad_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_stream_reader
// Brief    : Issues sequential scratchpad reads and drains the returning words
//            to a master AXI-Stream through a credit-checked output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module scratchpad_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           len,
    input  logic                  wr_busy,
    output logic                  busy,
    output logic                  done,
    output logic                  dma_rd_en,
    output logic [15:0]           dma_read_pointer,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_len;
    logic [15:0]             r_issued;
    logic [15:0]             r_accepted;
    logic                    r_done;
    logic [RD_LATENCY-1:0]   r_pipe;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wptr;
    logic [c_PTR_W-1:0]      r_rptr;
    logic [c_CNT_W-1:0]      r_count;

    logic                    w_start_ok;
    logic                    w_start_run;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_pop;
    logic                    w_issue;
    logic [c_OCC_W-1:0]      w_in_flight;
    logic [c_OCC_W-1:0]      w_occupied;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_start_run = w_start_ok && (len != 16'd0);
    assign w_push      = r_pipe[RD_LATENCY-1];
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    assign w_last_pop  = w_pop && m_axis_tlast;

    // Every word in the latency pipe already owns a FIFO slot; a pop this
    // cycle returns its slot in time for this cycle's issue decision.
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_in_flight = w_in_flight + c_OCC_W'(r_pipe[i]);
        end
    end

    assign w_occupied = w_in_flight + c_OCC_W'(r_count) - c_OCC_W'(w_pop);
    assign w_issue    = (r_state == S_RUN) && !wr_busy && (r_issued < r_len)
                        && (w_occupied < c_OCC_W'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_run) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && ((r_issued + 16'd1) == r_len)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_done     <= 1'b0;
            r_pipe     <= '0;
        end else begin
            r_done <= (w_start_ok && (len == 16'd0)) || ((r_state == S_DRAIN) && w_last_pop);
            r_pipe <= (r_pipe << 1) | RD_LATENCY'(w_issue);
            if (w_start_run) begin
                r_len      <= len;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_issue) r_issued   <= r_issued + 16'd1;
                if (w_pop)   r_accepted <= r_accepted + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= dma_rd_data;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && (r_count == c_CNT_W'(FIFO_DEPTH))));
        end
    end
`endif

    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign dma_rd_en        = w_issue;
    assign dma_read_pointer = r_issued;
    assign m_axis_tvalid    = (r_count != '0);
    assign m_axis_tdata     = r_mem[r_rptr];
    assign m_axis_tlast     = m_axis_tvalid && (r_accepted == (r_len - 16'd1));

endmodule
`default_nettype wire
